// File: rtl/traffic_pkg.sv
// Shared constants for the intersection conflict monitor: light codes,
// fault codes, direction indices, monitor FSM encoding and small helpers.
// Pure declarations, no logic and no latency; nothing here applies backpressure.
package traffic_pkg;

  // Signal-head codes
  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b01;
  localparam logic [1:0] LIGHT_GREEN   = 2'b10;
  localparam logic [1:0] LIGHT_INVALID = 2'b11;

  // Fault codes; a lower value means a higher reporting priority
  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_BAD_CODE     = 3'd1;
  localparam logic [2:0] FC_CONFLICT     = 3'd2;
  localparam logic [2:0] FC_BAD_SEQ      = 3'd3;
  localparam logic [2:0] FC_SHORT_GREEN  = 3'd4;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;
  localparam logic [2:0] FC_STARVE       = 3'd6;

  // Direction indices; bit order of every per-direction vector
  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } mon_state_t;

  // Lowest set index wins, giving the N > E > S > W tie-break.
  // Only meaningful when at least one bit is set.
  function automatic logic [1:0] first_dir(input logic [3:0] v);
    logic [1:0] d;
    if (v[0])      d = DIR_N;
    else if (v[1]) d = DIR_E;
    else if (v[2]) d = DIR_S;
    else           d = DIR_W;
    return d;
  endfunction

  function automatic logic [2:0] count_set(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/light_dir_tracker.sv
// Per-direction tracker: registers one signal head, remembers the previous
// sample and how long each value has been held, and flags per-head violations.
// Flags are combinational from the registered samples (1 cycle after input); never stalls.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   light          raw head code from the controller
//   sample         registered head code (used by the top for conflict/all-red)
//   is_bad_code    sample is the invalid code
//   bad_seq        sample changed along an illegal edge (changes to invalid excluded)
//   short_green    GREEN->YELLOW after fewer than MIN_GREEN cycles of green
//   short_yellow   YELLOW->RED after fewer than MIN_YELLOW cycles of yellow
//   starve         RED held longer than MAX_RED cycles
//   g2y            a GREEN->YELLOW edge is present this cycle
module light_dir_tracker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 20,
  parameter int MIN_YELLOW = 5,
  parameter int MAX_RED    = 400,
  parameter int CNT_W      = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] light,
  output logic [1:0] sample,
  output logic       is_bad_code,
  output logic       bad_seq,
  output logic       short_green,
  output logic       short_yellow,
  output logic       starve,
  output logic       g2y
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_G_CNT = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y_CNT = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_R_CNT = CNT_W'(MAX_RED);

  logic [1:0]       prev;
  logic [CNT_W-1:0] dwell;      // cycles the current sample has been held
  logic [CNT_W-1:0] old_dwell;  // hold time of the value that was just replaced

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample    <= LIGHT_RED;
      prev      <= LIGHT_RED;
      dwell     <= '0;
      old_dwell <= '0;
    end else begin
      prev   <= sample;
      sample <= light;
      if (light != sample) begin
        // Capture the finished run length so the transition checks, which
        // see the change one cycle later, can still judge the old value.
        dwell     <= CNT_W'(1);
        old_dwell <= dwell;
      end else if (dwell != CNT_MAX) begin
        dwell <= dwell + CNT_W'(1);
      end
    end
  end

  logic changed;
  logic legal_edge;

  assign changed    = (sample != prev);
  assign legal_edge = ((prev == LIGHT_GREEN)  && (sample == LIGHT_YELLOW)) ||
                      ((prev == LIGHT_YELLOW) && (sample == LIGHT_RED))    ||
                      ((prev == LIGHT_RED)    && (sample == LIGHT_GREEN));

  assign is_bad_code  = (sample == LIGHT_INVALID);
  // A change into the invalid code is reported as a bad code, not a bad sequence
  assign bad_seq      = changed && !legal_edge && (sample != LIGHT_INVALID);
  assign g2y          = (prev == LIGHT_GREEN) && (sample == LIGHT_YELLOW);
  assign short_green  = g2y && (old_dwell < MIN_G_CNT);
  assign short_yellow = (prev == LIGHT_YELLOW) && (sample == LIGHT_RED) &&
                        (old_dwell < MIN_Y_CNT);
  assign starve       = (sample == LIGHT_RED) && (dwell > MAX_R_CNT);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor on the four intersection signal heads: detects conflicts,
// illegal/short phases, invalid codes and red starvation, latches the first fault.
// Fault outputs update 2 edges after the offending light value; observe-only, no backpressure.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   light_n/e/s/w                   head codes (00 RED, 01 YELLOW, 10 GREEN, 11 invalid)
//   clear_fault                     one-cycle request to release a latched fault
//   fault, flash_red                fault latched / fail-safe flashing request (both = in FAULT)
//   fault_code, fault_dir           first latched fault and its direction
//   green_count                     GREEN->YELLOW phases completed while monitoring (wraps)
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 20,
  parameter int MIN_YELLOW = 5,
  parameter int MAX_RED    = 400,
  parameter int CNT_W      = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  light_n,
  input  logic [1:0]  light_e,
  input  logic [1:0]  light_s,
  input  logic [1:0]  light_w,
  input  logic        clear_fault,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  fault_dir,
  output logic        flash_red,
  output logic [15:0] green_count
);

  logic [3:0][1:0] light_v;
  logic [3:0][1:0] sample_v;
  logic [3:0]      bad_code_v;
  logic [3:0]      bad_seq_v;
  logic [3:0]      short_green_v;
  logic [3:0]      short_yellow_v;
  logic [3:0]      starve_v;
  logic [3:0]      g2y_v;

  assign light_v[DIR_N] = light_n;
  assign light_v[DIR_E] = light_e;
  assign light_v[DIR_S] = light_s;
  assign light_v[DIR_W] = light_w;

  for (genvar d = 0; d < 4; d++) begin : g_dir
    light_dir_tracker #(
      .MIN_GREEN  (MIN_GREEN),
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_RED    (MAX_RED),
      .CNT_W      (CNT_W)
    ) u_trk (
      .clk          (clk),
      .reset_n      (reset_n),
      .light        (light_v[d]),
      .sample       (sample_v[d]),
      .is_bad_code  (bad_code_v[d]),
      .bad_seq      (bad_seq_v[d]),
      .short_green  (short_green_v[d]),
      .short_yellow (short_yellow_v[d]),
      .starve       (starve_v[d]),
      .g2y          (g2y_v[d])
    );
  end

  // Right-of-way conflict: the N/S axis and the E/W axis both showing
  // something other than red. N and S together (or E and W) is normal.
  logic ns_active;
  logic ew_active;
  logic conflict;
  logic all_red;

  assign ns_active = (sample_v[DIR_N] != LIGHT_RED) || (sample_v[DIR_S] != LIGHT_RED);
  assign ew_active = (sample_v[DIR_E] != LIGHT_RED) || (sample_v[DIR_W] != LIGHT_RED);
  assign conflict  = ns_active && ew_active;
  assign all_red   = (sample_v[DIR_N] == LIGHT_RED) && (sample_v[DIR_E] == LIGHT_RED) &&
                     (sample_v[DIR_S] == LIGHT_RED) && (sample_v[DIR_W] == LIGHT_RED);

  // Priority encoder: lowest fault code first, then N > E > S > W
  logic [2:0] viol_code;
  logic [1:0] viol_dir;
  logic       viol;

  always_comb begin
    viol_code = FC_NONE;
    viol_dir  = DIR_N;
    if (|bad_code_v) begin
      viol_code = FC_BAD_CODE;
      viol_dir  = first_dir(bad_code_v);
    end else if (conflict) begin
      viol_code = FC_CONFLICT;
      viol_dir  = (sample_v[DIR_N] != LIGHT_RED) ? DIR_N : DIR_S;
    end else if (|bad_seq_v) begin
      viol_code = FC_BAD_SEQ;
      viol_dir  = first_dir(bad_seq_v);
    end else if (|short_green_v) begin
      viol_code = FC_SHORT_GREEN;
      viol_dir  = first_dir(short_green_v);
    end else if (|short_yellow_v) begin
      viol_code = FC_SHORT_YELLOW;
      viol_dir  = first_dir(short_yellow_v);
    end else if (|starve_v) begin
      viol_code = FC_STARVE;
      viol_dir  = first_dir(starve_v);
    end
  end

  assign viol = (viol_code != FC_NONE);

  // Monitor FSM with the latched fault record and the phase counter
  mon_state_t  state_q, state_d;
  logic [2:0]  code_q, code_d;
  logic [1:0]  dir_q, dir_d;
  logic [15:0] gc_q, gc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ARM;
      code_q  <= FC_NONE;
      dir_q   <= DIR_N;
      gc_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      gc_q    <= gc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dir_d   = dir_q;
    gc_d    = gc_q;
    unique case (state_q)
      ST_ARM: begin
        if (all_red) state_d = ST_MONITOR;
      end
      ST_MONITOR: begin
        // Two heads ending green on the same edge count as two phases
        gc_d = gc_q + 16'(count_set(g2y_v));
        if (viol) begin
          state_d = ST_FAULT;
          code_d  = viol_code;
          dir_d   = viol_dir;
        end
      end
      ST_FAULT: begin
        // Release only onto a clean sample, otherwise the request is dropped
        if (clear_fault && !viol) begin
          state_d = ST_ARM;
          code_d  = FC_NONE;
          dir_d   = DIR_N;
        end
      end
      default: begin
        state_d = ST_ARM;
        code_d  = FC_NONE;
        dir_d   = DIR_N;
      end
    endcase
  end

  assign fault       = (state_q == ST_FAULT);
  assign flash_red   = (state_q == ST_FAULT);
  assign fault_code  = code_q;
  assign fault_dir   = dir_q;
  assign green_count = gc_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios plus randomized light
// traffic, checked every cycle against a history-based reference model.
module tb_traffic_conflict_monitor;

  localparam int MING = 4;
  localparam int MINY = 2;
  localparam int MAXR = 20;
  localparam int R = 0, Y = 1, G = 2, X = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  light_n, light_e, light_s, light_w;
  logic        clear_fault;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  fault_dir;
  logic        flash_red;
  logic [15:0] green_count;

  always #5 clk = ~clk;

  traffic_conflict_monitor #(
    .MIN_GREEN  (MING),
    .MIN_YELLOW (MINY),
    .MAX_RED    (MAXR),
    .CNT_W      (10)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .light_n     (light_n),
    .light_e     (light_e),
    .light_s     (light_s),
    .light_w     (light_w),
    .clear_fault (clear_fault),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_dir   (fault_dir),
    .flash_red   (flash_red),
    .green_count (green_count)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // hist[d][k] is the registered sample after the k-th edge since reset;
  // index 0 stands for the reset value (RED, zero hold time).
  logic [1:0] hist [4][0:4095];
  int n;
  int m_state;   // 0 = arming, 1 = monitoring, 2 = faulted
  int m_code;
  int m_dir;
  int m_gc;

  task automatic model_reset();
    n = 0;
    for (int d = 0; d < 4; d++) hist[d][0] = 2'(R);
    m_state = 0;
    m_code  = 0;
    m_dir   = 0;
    m_gc    = 0;
  endtask

  // Number of consecutive equal samples ending at idx (reset entry excluded), capped
  function automatic int runlen(int d, int idx);
    int c;
    int i;
    c = 0;
    i = idx;
    while (i >= 1 && c < 1023 && hist[d][i] == hist[d][idx]) begin
      c++;
      i--;
    end
    return c;
  endfunction

  task automatic eval_viol(output int code, output int dir, output int g2y_cnt, output bit all_red);
    int cur[4];
    int prv[4];
    int dw[4];
    int od[4];
    bit conf;
    bit hit;
    for (int d = 0; d < 4; d++) begin
      cur[d] = int'(hist[d][n]);
      prv[d] = int'(hist[d][(n > 0) ? n - 1 : 0]);
      dw[d]  = runlen(d, n);
      od[d]  = runlen(d, n - 1);
    end
    conf = ((cur[0] != R) || (cur[2] != R)) && ((cur[1] != R) || (cur[3] != R));
    all_red = (cur[0] == R) && (cur[1] == R) && (cur[2] == R) && (cur[3] == R);
    g2y_cnt = 0;
    for (int d = 0; d < 4; d++) if (prv[d] == G && cur[d] == Y) g2y_cnt++;
    code = 0;
    dir  = 0;
    for (int c = 1; c <= 6; c++) begin
      for (int d = 0; d < 4; d++) begin
        case (c)
          1: hit = (cur[d] == X);
          2: hit = conf && ((d == 0 && cur[0] != R) || (d == 2 && cur[0] == R));
          3: hit = (cur[d] != prv[d]) && (cur[d] != X) &&
                   !((prv[d] == G && cur[d] == Y) || (prv[d] == Y && cur[d] == R) ||
                     (prv[d] == R && cur[d] == G));
          4: hit = (prv[d] == G) && (cur[d] == Y) && (od[d] < MING);
          5: hit = (prv[d] == Y) && (cur[d] == R) && (od[d] < MINY);
          default: hit = (cur[d] == R) && (dw[d] > MAXR);
        endcase
        if (hit && code == 0) begin
          code = c;
          dir  = d;
        end
      end
    end
  endtask

  task automatic model_step();
    int vc, vd, g;
    bit ar;
    eval_viol(vc, vd, g, ar);
    case (m_state)
      0: if (ar) m_state = 1;
      1: begin
        m_gc = (m_gc + g) % 65536;
        if (vc != 0) begin
          m_state = 2;
          m_code  = vc;
          m_dir   = vd;
        end
      end
      default: if (clear_fault && vc == 0) begin
        m_state = 0;
        m_code  = 0;
        m_dir   = 0;
      end
    endcase
    n++;
    hist[0][n] = light_n;
    hist[1][n] = light_e;
    hist[2][n] = light_s;
    hist[3][n] = light_w;
  endtask

  // ---------------- checking ----------------
  task automatic compare();
    bit ef;
    ef = (m_state == 2);
    checks++;
    if (fault !== ef || flash_red !== ef || fault_code !== 3'(m_code) ||
        fault_dir !== 2'(m_dir) || green_count !== 16'(m_gc)) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t fault=%0d/%0d flash=%0d/%0d code=%0d/%0d dir=%0d/%0d gc=%0d/%0d (got/req)",
               $time, fault, ef, flash_red, ef, fault_code, m_code, fault_dir, m_dir, green_count, m_gc);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(int k);
    repeat (k) begin
      @(posedge clk);
      if (reset_n) model_step();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic set_l(int vn, int ve, int vs, int vw);
    light_n = 2'(vn);
    light_e = 2'(ve);
    light_s = 2'(vs);
    light_w = 2'(vw);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    clear_fault = 1'b0;
    set_l(R, R, R, R);
    model_reset();
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
  endtask

  int ph, left;

  initial begin
    reset_n     = 1'b0;
    clear_fault = 1'b0;
    set_l(R, R, R, R);
    model_reset();
    #1;
    chk("reset_fault", int'(fault), 0);
    chk("reset_flash", int'(flash_red), 0);
    chk("reset_code", int'(fault_code), 0);
    chk("reset_gc", int'(green_count), 0);
    @(negedge clk);

    // 1: legal N/S then E/W phases
    do_reset();
    set_l(G, R, G, R); cyc(5);
    set_l(Y, R, Y, R); cyc(3);
    set_l(R, R, R, R); cyc(1);
    set_l(R, G, R, G); cyc(5);
    set_l(R, Y, R, Y); cyc(3);
    set_l(R, R, R, R); cyc(2);
    chk("t1_fault", int'(fault), 0);
    chk("t1_gc", int'(green_count), 4);

    // 2: conflict, two-edge latency
    do_reset();
    set_l(G, G, R, R); cyc(1);
    chk("t2_latency", int'(fault), 0);
    cyc(1);
    chk("t2_fault", int'(fault), 1);
    chk("t2_code", int'(fault_code), 2);
    chk("t2_dir", int'(fault_dir), 0);
    chk("t2_flash", int'(flash_red), 1);

    // 3: short green, then exact minimum green and yellow
    do_reset();
    set_l(G, R, R, R); cyc(3);
    set_l(Y, R, R, R); cyc(2);
    chk("t3_code", int'(fault_code), 4);
    chk("t3_dir", int'(fault_dir), 0);
    do_reset();
    set_l(G, R, R, R); cyc(4);
    set_l(Y, R, R, R); cyc(2);
    set_l(R, R, R, R); cyc(2);
    chk("t3_boundary_fault", int'(fault), 0);
    chk("t3_boundary_gc", int'(green_count), 1);

    // 4: bad sequence, then bad code beating a bad sequence
    do_reset();
    set_l(R, Y, R, R); cyc(2);
    chk("t4_seq_code", int'(fault_code), 3);
    chk("t4_seq_dir", int'(fault_dir), 1);
    do_reset();
    set_l(R, R, G, R); cyc(5);
    set_l(R, R, R, X); cyc(2);
    chk("t4_prio_code", int'(fault_code), 1);
    chk("t4_prio_dir", int'(fault_dir), 3);

    // 5: west starvation, refused clear, accepted clear
    do_reset();
    set_l(R, G, R, R); cyc(4);
    set_l(R, Y, R, R); cyc(2);
    for (int i = 0; i < 18; i++) begin
      if (i % 9 < 5)      set_l(G, R, G, R);
      else if (i % 9 < 8) set_l(Y, R, Y, R);
      else                set_l(R, R, R, R);
      cyc(1);
    end
    chk("t5_code", int'(fault_code), 6);
    chk("t5_dir", int'(fault_dir), 3);
    set_l(R, R, R, R);
    clear_fault = 1'b1; cyc(1);
    clear_fault = 1'b0; cyc(1);
    chk("t5_clear_refused", int'(fault), 1);
    set_l(X, X, X, X); cyc(1);
    set_l(R, R, R, R); cyc(3);
    clear_fault = 1'b1; cyc(1);
    clear_fault = 1'b0;
    chk("t5_cleared_fault", int'(fault), 0);
    chk("t5_cleared_code", int'(fault_code), 0);
    cyc(1);
    set_l(R, Y, R, R); cyc(2);
    chk("t5_rearmed_code", int'(fault_code), 3);

    // 6: asynchronous reset while faulted
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_fault", int'(fault), 0);
    chk("t6_flash", int'(flash_red), 0);
    chk("t6_code", int'(fault_code), 0);
    model_reset();
    set_l(R, R, R, R);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    chk("t6_after_release", int'(fault), 0);

    // Randomized traffic: controller-like with glitches, then free-running noise
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      ph = 0;
      left = 3;
      for (int i = 0; i < 250; i++) begin
        if (blk % 2 == 0) begin
          if (left == 0) begin
            ph = (ph + 1) % 6;
            case (ph)
              0, 3:    left = $urandom_range(3, 6);
              1, 4:    left = $urandom_range(1, 3);
              default: left = $urandom_range(1, 2);
            endcase
          end
          left--;
          case (ph)
            0: set_l(G, R, G, R);
            1: set_l(Y, R, Y, R);
            3: set_l(R, G, R, G);
            4: set_l(R, Y, R, Y);
            default: set_l(R, R, R, R);
          endcase
          if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 3))
              0: light_n = 2'($urandom_range(0, 3));
              1: light_e = 2'($urandom_range(0, 3));
              2: light_s = 2'($urandom_range(0, 3));
              default: light_w = 2'($urandom_range(0, 3));
            endcase
          end
        end else begin
          if ($urandom_range(0, 5) == 0) light_n = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 5) == 0) light_e = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 5) == 0) light_s = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 5) == 0) light_w = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 7) == 0) set_l(R, R, R, R);
        end
        clear_fault = ($urandom_range(0, 9) == 0);
        cyc(1);
      end
      clear_fault = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
